// File: rtl/subckt_pkg.sv
// Shared types, constants and the golden response model for the sub-circuit stimulus driver.
package subckt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Feedback taps for x^4 + x^3 + 1 on a left-shifting 4-bit register.
  localparam logic [3:0] LFSR_TAPS     = 4'b1100;
  localparam logic [3:0] LFSR_SEED_DEF = 4'b0001;

  function automatic logic golden_exp(input logic [3:0] s);
    return (s[2] & (s[0] | s[1])) ^ (s[0] & s[1]);
  endfunction

endpackage

// File: rtl/subckt_lfsr4.sv
// 4-bit Fibonacci LFSR (x^4 + x^3 + 1, period 15) with synchronous load and step enable.
module subckt_lfsr4
  import subckt_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] seed_i,
  input  logic       en_i,
  output logic [3:0] state_o
);

  logic [3:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (en_i) begin
      state_d = {state_q[2:0], ^(state_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= 4'h0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/subckt_stim_driver.sv
// Drives counting or LFSR patterns into a 4-input sub-circuit and counts responses that differ from the golden model.
// Toggle counting on {stim_o, resp_i} is built only when SUBCKT_TOGGLE_CNT_EN is defined.
module subckt_stim_driver
  import subckt_pkg::*;
#(
  parameter int unsigned PAT_W     = 16,
  parameter int unsigned RESP_LAT  = 0,
  parameter logic [3:0]  LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [PAT_W-1:0] num_pat_i,
  output logic [3:0]       stim_o,
  input  logic             resp_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             ack_i,
  output logic [PAT_W-1:0] mism_cnt_o,
  output logic [PAT_W-1:0] tgl_cnt_o
);

  localparam logic [1:0] DRN_INIT = (RESP_LAT == 0) ? 2'd0 : 2'(RESP_LAT - 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [PAT_W-1:0] rem_q, rem_d;
  logic [1:0]       drn_q, drn_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PAT_W-1:0] mism_q, mism_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             lfsr_load;
  logic             lfsr_en;
  logic [3:0]       lfsr_state;
  logic             start_acc;
  logic             run_now;
  logic             exp_now;
  logic             cmp_vld;
  logic             cmp_exp;

  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign run_now   = (state_q == ST_RUN);

  subckt_lfsr4 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .seed_i  (LFSR_SEED),
    .en_i    (lfsr_en),
    .state_o (lfsr_state)
  );

  assign stim_o  = mode_q ? lfsr_state : cnt_q;
  assign exp_now = golden_exp(stim_o);

  // rem_q counts patterns still to apply after the current one; the last pattern is held, not stepped.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rem_d     = rem_q;
    drn_d     = drn_q;
    cnt_d     = cnt_q;
    mism_d    = mism_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mism_d = '0;
          if (num_pat_i == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_RUN;
            mode_d    = mode_i;
            rem_d     = num_pat_i - 1'b1;
            cnt_d     = 4'h0;
            lfsr_load = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rem_q == '0) begin
          state_d = (RESP_LAT == 0) ? ST_DONE : ST_DRAIN;
          drn_d   = DRN_INIT;
        end else begin
          rem_d   = rem_q - 1'b1;
          cnt_d   = cnt_q + 4'd1;
          lfsr_en = mode_q;
        end
      end
      ST_DRAIN: begin
        if (drn_q == 2'd0) begin
          state_d = ST_DONE;
        end else begin
          drn_d = drn_q - 2'd1;
        end
      end
      ST_DONE: begin
        if (ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cmp_vld && (cmp_exp != resp_i) && (mism_q != '1)) begin
      mism_d = mism_q + 1'b1;
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      rem_q   <= '0;
      drn_q   <= 2'd0;
      cnt_q   <= 4'h0;
      mism_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      drn_q   <= drn_d;
      cnt_q   <= cnt_d;
      mism_q  <= mism_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign mism_cnt_o = mism_q;

  // Expected-response delay line: a RUN-qualified valid bit travels with each expected value.
  generate
    if (RESP_LAT == 0) begin : g_nodly
      assign cmp_vld = run_now;
      assign cmp_exp = exp_now;
    end else begin : g_dly
      logic [RESP_LAT-1:0] vld_q, vld_d;
      logic [RESP_LAT-1:0] exp_q, exp_d;

      always_comb begin
        vld_d = (vld_q << 1) | RESP_LAT'(run_now);
        exp_d = (exp_q << 1) | RESP_LAT'(exp_now);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          exp_q <= '0;
        end else begin
          vld_q <= vld_d;
          exp_q <= exp_d;
        end
      end

      assign cmp_vld = vld_q[RESP_LAT-1];
      assign cmp_exp = exp_q[RESP_LAT-1];
    end
  endgenerate

`ifdef SUBCKT_TOGGLE_CNT_EN
  logic [4:0]       tvec_q, tvec_d;
  logic [PAT_W-1:0] tgl_q, tgl_d;
  logic [2:0]       hd;
  logic [PAT_W:0]   tgl_sum;

  always_comb begin
    tvec_d  = {stim_o, resp_i};
    hd      = 3'($countones(tvec_d ^ tvec_q));
    tgl_sum = {1'b0, tgl_q} + (PAT_W + 1)'(hd);
    tgl_d   = tgl_q;
    if (start_acc) begin
      tgl_d = '0;
    end else if (busy_q) begin
      tgl_d = tgl_sum[PAT_W] ? '1 : tgl_sum[PAT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvec_q <= 5'h00;
      tgl_q  <= '0;
    end else begin
      tvec_q <= tvec_d;
      tgl_q  <= tgl_d;
    end
  end

  assign tgl_cnt_o = tgl_q;
`else
  assign tgl_cnt_o = '0;
`endif

endmodule

// File: tb/tb_subckt_stim_driver.sv
// Bench for subckt_stim_driver: two instances (response latency 0 and 2) share stimulus; a timeline model checks every cycle.
`timescale 1ns/1ps
module tb_subckt_stim_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_i;
  logic        mode_i;
  logic        ack_i;
  logic [15:0] num_pat;
  logic [1:0]  rmode;   // 0 ideal sub-circuit, 1 stuck-0, 2 stuck-1

  logic [1:0][3:0]  d_stim;
  logic [1:0]       d_busy;
  logic [1:0]       d_done;
  logic [1:0][15:0] d_mism;
  logic [1:0][15:0] d_tgl;
  logic             resp0, resp1;
  logic [3:0]       hist_a, hist_b;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic ref_exp(input logic [3:0] s);
    int a, b, c;
    a = int'(s[0]);
    b = int'(s[1]);
    c = int'(s[2]);
    return 1'((c * (a | b) + a * b) % 2);
  endfunction

  function automatic logic [3:0] lnext(input logic [3:0] s);
    int v;
    v = int'(s);
    return 4'(((v * 2) % 16) + (((v / 8) + (v / 4)) % 2));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    hist_a <= d_stim[1];
    hist_b <= hist_a;
  end

  assign resp0 = (rmode == 2'd0) ? ref_exp(d_stim[0]) : (rmode == 2'd2);
  assign resp1 = (rmode == 2'd0) ? ref_exp(hist_b)    : (rmode == 2'd2);

  subckt_stim_driver #(.PAT_W(16), .RESP_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .num_pat_i(num_pat),
    .stim_o(d_stim[0]), .resp_i(resp0), .busy_o(d_busy[0]), .done_o(d_done[0]),
    .ack_i(ack_i), .mism_cnt_o(d_mism[0]), .tgl_cnt_o(d_tgl[0])
  );

  subckt_stim_driver #(.PAT_W(16), .RESP_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .num_pat_i(num_pat),
    .stim_o(d_stim[1]), .resp_i(resp1), .busy_o(d_busy[1]), .done_o(d_done[1]),
    .ack_i(ack_i), .mism_cnt_o(d_mism[1]), .tgl_cnt_o(d_tgl[1])
  );

  // Model: a run is a timeline of t cycles since the accepting edge; patterns are precomputed at start.
  int         m_act  [2];
  int         m_t    [2];
  int         m_n    [2];
  int         m_mism [2];
  logic [3:0] m_last [2];
  logic [3:0] m_pat  [2][64];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_n[i] = 0; m_mism[i] = 0; m_last[i] = 4'h0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_t[i] = 0; m_mism[i] = 0; m_last[i] = 4'h0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      int lat, dl, idx;
      logic [3:0] es, s;
      logic eb, ed, r;
      lat = (i == 0) ? 0 : 2;
      dl  = (m_n[i] == 0) ? 0 : m_n[i] + lat;
      es  = m_last[i];
      eb  = 1'b0;
      ed  = 1'b0;
      if (m_act[i] != 0) begin
        if (m_n[i] > 0) begin
          idx = (m_t[i] < m_n[i]) ? m_t[i] : m_n[i] - 1;
          es  = m_pat[i][idx];
        end
        eb = (m_t[i] < dl);
        ed = !eb;
      end
      chk($sformatf("d%0d_stim", i), 32'(d_stim[i]), 32'(es));
      chk($sformatf("d%0d_busy", i), 32'(d_busy[i]), 32'(eb));
      chk($sformatf("d%0d_done", i), 32'(d_done[i]), 32'(ed));
      chk($sformatf("d%0d_mism", i), 32'(d_mism[i]), 32'(m_mism[i]));
      chk($sformatf("d%0d_tgl", i),  32'(d_tgl[i]),  32'd0);

      if (!rst) begin
        r = (i == 0) ? resp0 : resp1;
        if (m_act[i] == 0) begin
          if (start_i) begin
            m_act[i]  = 1;
            m_t[i]    = 0;
            m_n[i]    = (int'(num_pat) > 64) ? 64 : int'(num_pat);
            m_mism[i] = 0;
            s = mode_i ? 4'h1 : 4'h0;
            for (int k = 0; k < m_n[i]; k++) begin
              m_pat[i][k] = s;
              s = mode_i ? lnext(s) : 4'((int'(s) + 1) % 16);
            end
            if (m_n[i] > 0) m_last[i] = m_pat[i][m_n[i] - 1];
          end
        end else if (m_t[i] >= dl) begin
          if (ack_i) m_act[i] = 0;
        end else begin
          if (m_t[i] >= lat && m_t[i] < m_n[i] + lat) begin
            if (ref_exp(m_pat[i][m_t[i] - lat]) != r) m_mism[i]++;
          end
          m_t[i]++;
        end
      end
    end
  end

  logic [3:0] stim_log [64];
  int         nlog;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input logic m, input int n, input logic [1:0] rm,
                        output int b0, output int b1);
    rmode   = rm;
    mode_i  = m;
    num_pat = 16'(n);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    b0 = 0; b1 = 0; nlog = 0;
    for (int c = 0; c < 200; c++) begin
      if (d_done[0] && d_done[1]) break;
      if (d_busy[0]) begin
        if (nlog < 64) stim_log[nlog] = d_stim[0];
        nlog++;
        b0++;
      end
      if (d_busy[1]) b1++;
      cyc();
    end
    chk("run_reaches_done", 32'({d_done[1], d_done[0]}), 32'h3);
  endtask

  task automatic do_ack();
    ack_i = 1'b1;
    cyc();
    ack_i = 1'b0;
    chk("ack_clears_done", 32'(d_done), 32'h0);
  endtask

  initial begin
    int b0, b1, found;
    logic [15:0] seen;
    rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; ack_i = 1'b0; num_pat = 16'd0; rmode = 2'd0;
    cyc(); cyc();
    chk("reset_stim", 32'(d_stim), 32'h0);
    chk("reset_busy_done", 32'({d_busy, d_done}), 32'h0);
    chk("reset_mism", 32'(d_mism[0]), 32'h0);
    rst = 1'b0;

    // Counting mode, 16 patterns, ideal sub-circuit.
    do_run(1'b0, 16, 2'd0, b0, b1);
    chk("m0_run_cycles", 32'(b0), 32'd16);
    chk("m0_lat2_busy", 32'(b1), 32'd18);
    for (int k = 0; k < 16; k++) chk("m0_stim_seq", 32'(stim_log[k]), 32'(k));
    chk("m0_mism", 32'(d_mism[0]), 32'd0);
    do_ack();

    // LFSR mode, full period.
    do_run(1'b1, 15, 2'd0, b0, b1);
    seen = 16'h0;
    for (int k = 0; k < 15; k++) seen[stim_log[k]] = 1'b1;
    chk("lfsr_distinct_nonzero", 32'(seen), 32'h0000FFFE);
    chk("lfsr_first", 32'(stim_log[0]), 32'h1);
    chk("lfsr_last", 32'(stim_log[14]), 32'h8);
    chk("lfsr_wraps_to_seed", 32'(lnext(stim_log[14])), 32'h1);
    chk("lfsr_mism", 32'(d_mism[0]), 32'd0);
    do_ack();

    // Stuck-0 response: mismatch on every pattern whose expected value is 1.
    do_run(1'b0, 16, 2'd1, b0, b1);
    chk("stuck0_mism_lat0", 32'(d_mism[0]), 32'd6);
    chk("stuck0_mism_lat2", 32'(d_mism[1]), 32'd6);
    do_ack();
    chk("idle_holds_mism", 32'(d_mism[0]), 32'd6);

    // Zero patterns: straight to DONE with cleared counters, then start+ack together.
    num_pat = 16'd0; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    chk("zero_done", 32'(d_done), 32'h3);
    chk("zero_busy", 32'(d_busy), 32'h0);
    chk("zero_mism", 32'(d_mism[0]), 32'd0);
    num_pat = 16'd5; start_i = 1'b1; ack_i = 1'b1;
    cyc();
    start_i = 1'b0; ack_i = 1'b0;
    chk("start_ack_done", 32'(d_done), 32'h0);
    chk("start_ack_busy", 32'(d_busy), 32'h0);
    cyc();
    chk("start_not_latched", 32'({d_busy, d_done}), 32'h0);

    // Latency-2 drain.
    do_run(1'b0, 20, 2'd0, b0, b1);
    chk("lat2_drain_cycles", 32'(b1 - 20), 32'd2);
    chk("lat0_run_cycles", 32'(b0), 32'd20);
    chk("lat2_mism", 32'(d_mism[1]), 32'd0);
    do_ack();

    // Reset in the middle of a run.
    rmode = 2'd1; mode_i = 1'b0; num_pat = 16'd16; start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    found = 0;
    for (int c = 0; c < 40; c++) begin
      if (d_stim[0] == 4'h7) begin found = 1; break; end
      cyc();
    end
    chk("reach_pattern7", 32'(found), 32'd1);
    chk("pre_reset_mism", 32'(d_mism[0]), 32'd3);
    rst = 1'b1;
    #1;
    chk("midrst_stim", 32'(d_stim), 32'h0);
    chk("midrst_busy_done", 32'({d_busy, d_done}), 32'h0);
    chk("midrst_mism", 32'({d_mism[1], d_mism[0]}), 32'h0);
    cyc();
    rst = 1'b0;
    cyc();
    do_run(1'b1, 10, 2'd2, b0, b1);
    chk("post_rst_stuck1_lat0", 32'(d_mism[0]), 32'd5);
    chk("post_rst_stuck1_lat2", 32'(d_mism[1]), 32'd5);
    chk("post_rst_cycles", 32'(b0), 32'd10);
    do_ack();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

endmodule
